// File: rtl/ccx_memif_dma_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ccx_memif_dma_pkg: shared state encoding and constants for the    |
// | CCX memory-interface word-copy engine.                            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package ccx_memif_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } dma_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int          DEF_LEN_W  = 16;

endpackage
`default_nettype wire

// File: rtl/scarv_ccx_memif.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scarv_ccx_memif: CCX memory bus, requester and responder views.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface scarv_ccx_memif;
    logic        req;
    logic        gnt;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;

    modport REQ (output req, wen, addr, wdata, input gnt, rdata, error);
    modport RSP (input req, wen, addr, wdata, output gnt, rdata, error);
endinterface
`default_nettype wire

// File: rtl/ccx_memif_dma_addr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ccx_memif_dma_addr: source/destination/count register bank with   |
// | load, advance and terminal-count outputs.                         |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ccx_memif_dma_addr
    import ccx_memif_dma_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    input  logic [31:0]      src_in,
    input  logic [31:0]      dst_in,
    input  logic [LEN_W-1:0] len_in,
    output logic [31:0]      dst,
    output logic [31:0]      src_next,
    output logic [31:0]      dst_next,
    output logic             last
);
    logic [31:0]      src;
    logic [LEN_W-1:0] cnt;
    logic             unused_lsbs;

    assign unused_lsbs = ^{src_in[1:0], dst_in[1:0]};

    // Natural 32-bit overflow gives the 0xFFFFFFFC -> 0x0 wrap.
    assign src_next = src + 32'(WORD_BYTES);
    assign dst_next = dst + 32'(WORD_BYTES);
    assign last     = (cnt == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src <= '0;
            dst <= '0;
            cnt <= '0;
        end else if (load) begin
            src <= {src_in[31:2], 2'b00};
            dst <= {dst_in[31:2], 2'b00};
            cnt <= len_in;
        end else if (adv) begin
            src <= src_next;
            dst <= dst_next;
            cnt <= cnt - LEN_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ccx_memif_dma.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ccx_memif_dma: word-copy bus initiator on the CCX memory bus.     |
// | Fill mode is built only when MEMIF_DMA_FILL_EN is defined.        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ccx_memif_dma
    import ccx_memif_dma_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    output logic              g_clk_req,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              fill_mode,
    input  logic [31:0]       fill_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       err_addr,
    scarv_ccx_memif.REQ       memif
);
    dma_state_t  state;
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        abort_pend;
    logic        accept;
    logic        adv;
    logic        fill_now;
    logic        fill_on;
    logic [31:0] fill_word;
    logic [31:0] dst;
    logic [31:0] src_next;
    logic [31:0] dst_next;
    logic        last;

    assign memif.req   = req;
    assign memif.wen   = wen;
    assign memif.addr  = addr;
    assign memif.wdata = wdata;
    assign g_clk_req   = start | busy;

    assign accept = (state == IDLE) && start;
    assign adv    = (state == WR) && req && memif.gnt && !memif.error;

`ifdef MEMIF_DMA_FILL_EN
    logic fill_q;
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)   fill_q <= 1'b0;
        else if (accept) fill_q <= fill_mode;
    end
    assign fill_now  = fill_mode;
    assign fill_on   = fill_q;
    assign fill_word = fill_data;
`else
    logic unused_fill;
    assign unused_fill = ^{fill_mode, fill_data};
    assign fill_now    = 1'b0;
    assign fill_on     = 1'b0;
    assign fill_word   = '0;
`endif

    ccx_memif_dma_addr #(.LEN_W(LEN_W)) u_addr (
        .clk      (g_clk),
        .rst_n    (g_resetn),
        .load     (accept),
        .adv      (adv),
        .src_in   (src_addr),
        .dst_in   (dst_addr),
        .len_in   (length),
        .dst      (dst),
        .src_next (src_next),
        .dst_next (dst_next),
        .last     (last)
    );

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state      <= IDLE;
            req        <= 1'b0;
            wen        <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_addr   <= '0;
            abort_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    err        <= 1'b0;
                    abort_pend <= 1'b0;
                    busy       <= 1'b1;
                    if (length == '0) begin
                        state <= FIN;
                    end else if (fill_now) begin
                        state <= WR;
                        req   <= 1'b1;
                        wen   <= 1'b1;
                        addr  <= {dst_addr[31:2], 2'b00};
                        wdata <= fill_word;
                    end else begin
                        state <= RD;
                        req   <= 1'b1;
                        wen   <= 1'b0;
                        addr  <= {src_addr[31:2], 2'b00};
                    end
                end
                RD: begin
                    if (abort) abort_pend <= 1'b1;
                    if (memif.gnt) begin
                        if (memif.error) begin
                            err      <= 1'b1;
                            err_addr <= addr;
                            req      <= 1'b0;
                            state    <= FIN;
                            done     <= 1'b1;
                        end else if (abort || abort_pend) begin
                            req   <= 1'b0;
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            wen   <= 1'b1;
                            addr  <= dst;
                            wdata <= memif.rdata;
                            state <= WR;
                        end
                    end
                end
                WR: begin
                    if (abort) abort_pend <= 1'b1;
                    if (memif.gnt) begin
                        if (memif.error || last || abort || abort_pend) begin
                            if (memif.error) begin
                                err      <= 1'b1;
                                err_addr <= addr;
                            end
                            req   <= 1'b0;
                            wen   <= 1'b0;
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (fill_on) begin
                            addr  <= dst_next;
                            wdata <= fill_word;
                        end else begin
                            wen   <= 1'b0;
                            addr  <= src_next;
                            state <= RD;
                        end
                    end
                end
                // A zero-length accept arrives here with done low and
                // spends one extra cycle raising it.
                FIN: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ccx_memif_dma.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ccx_memif_dma: directed bench for ccx_memif_dma with a bus     |
// | responder that returns {16'hC0DE, addr[15:0]} on reads.           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_ccx_memif_dma;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        fill_mode = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [31:0] fill_data = 32'hA5A5A5A5;
    logic [15:0] length = '0;
    logic        clk_req;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] err_addr;

    scarv_ccx_memif bus ();

    ccx_memif_dma dut (
        .g_clk     (clk),
        .g_resetn  (resetn),
        .g_clk_req (clk_req),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .fill_mode (fill_mode),
        .fill_data (fill_data),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_addr  (err_addr),
        .memif     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        log_q[$];
    int          stall_n = 0;
    int          wait_cnt = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_a = '0;
    logic        stab_en = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic        prev_wen = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    // Responder: grant after stall_n waiting cycles, data from address.
    always @(negedge clk) begin
        bus.gnt   = bus.req && (wait_cnt >= stall_n);
        bus.rdata = {16'hC0DE, bus.addr[15:0]};
        bus.error = err_en && bus.req && !bus.wen && (bus.addr == err_a);
    end

    always @(posedge clk) begin
        if (stab_en && prev_req && !prev_gnt) begin
            chk("stall_req",   {31'b0, bus.req}, 32'd1);
            chk("stall_addr",  bus.addr, prev_addr);
            chk("stall_wen",   {31'b0, bus.wen}, {31'b0, prev_wen});
            chk("stall_wdata", bus.wdata, prev_wdata);
        end
        if (bus.req && bus.gnt) begin
            log_q.push_back('{bus.wen, bus.addr, bus.wdata});
            wait_cnt = 0;
        end else if (bus.req) begin
            wait_cnt++;
        end
        prev_req   = bus.req;
        prev_gnt   = bus.gnt;
        prev_wen   = bus.wen;
        prev_addr  = bus.addr;
        prev_wdata = bus.wdata;
    end

    task automatic kick(input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] len, input logic fm);
        @(negedge clk);
        log_q.delete();
        src_addr  = s;
        dst_addr  = d;
        length    = len;
        fill_mode = fm;
        start     = 1'b1;
    endtask

    // Counts negedges after the start negedge until done is seen.
    task automatic wait_done(input int k0, input int abort_at, output int lat);
        lat = -1;
        for (int k = k0 + 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == abort_at) abort = 1'b1;
            if (k == abort_at + 1) abort = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic chk_txn(input string tag, input int i, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        if (i < log_q.size()) t = log_q[i];
        else                  t = '1;
        chk({tag, "_wen"},  {31'b0, t.wen}, {31'b0, w});
        chk({tag, "_addr"}, t.addr, a);
        if (w) chk({tag, "_wdata"}, t.wdata, d);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     {31'b0, busy}, 32'd0);
        chk("rst_done",     {31'b0, done}, 32'd0);
        chk("rst_err",      {31'b0, err}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_req",      {31'b0, bus.req}, 32'd0);
        chk("rst_wen",      {31'b0, bus.wen}, 32'd0);
        chk("rst_addr",     bus.addr, 32'd0);
        chk("rst_wdata",    bus.wdata, 32'd0);
        chk("rst_clk_req",  {31'b0, clk_req}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Zero-wait copy of three words.
        kick(32'h1000, 32'h2000, 16'd3, 1'b0);
        #1 chk("clk_req_on_start", {31'b0, clk_req}, 32'd1);
        wait_done(0, 0, lat);
        chk("copy_latency", lat, 32'd7);
        chk("copy_count", log_q.size(), 32'd6);
        chk_txn("copy0", 0, 1'b0, 32'h1000, 32'h0);
        chk_txn("copy1", 1, 1'b1, 32'h2000, 32'hC0DE1000);
        chk_txn("copy2", 2, 1'b0, 32'h1004, 32'h0);
        chk_txn("copy3", 3, 1'b1, 32'h2004, 32'hC0DE1004);
        chk_txn("copy4", 4, 1'b0, 32'h1008, 32'h0);
        chk_txn("copy5", 5, 1'b1, 32'h2008, 32'hC0DE1008);
        @(negedge clk);
        chk("copy_busy_after", {31'b0, busy}, 32'd0);
        chk("copy_done_pulse", {31'b0, done}, 32'd0);

        // Three wait states on every request.
        stall_n = 3;
        stab_en = 1'b1;
        kick(32'h3000, 32'h4000, 16'd2, 1'b0);
        wait_done(0, 0, lat);
        stab_en = 1'b0;
        stall_n = 0;
        chk("stall_latency", lat, 32'd17);
        chk("stall_count", log_q.size(), 32'd4);
        chk_txn("stall0", 0, 1'b0, 32'h3000, 32'h0);
        chk_txn("stall1", 1, 1'b1, 32'h4000, 32'hC0DE3000);
        chk_txn("stall2", 2, 1'b0, 32'h3004, 32'h0);
        chk_txn("stall3", 3, 1'b1, 32'h4004, 32'hC0DE3004);

        // Bus error on the second read.
        err_en = 1'b1;
        err_a  = 32'h1004;
        kick(32'h1000, 32'h2000, 16'd4, 1'b0);
        wait_done(0, 0, lat);
        err_en = 1'b0;
        chk("buserr_latency", lat, 32'd4);
        chk("buserr_err", {31'b0, err}, 32'd1);
        chk("buserr_err_addr", err_addr, 32'h1004);
        chk("buserr_count", log_q.size(), 32'd3);
        chk_txn("buserr0", 0, 1'b0, 32'h1000, 32'h0);
        chk_txn("buserr1", 1, 1'b1, 32'h2000, 32'hC0DE1000);
        chk_txn("buserr2", 2, 1'b0, 32'h1004, 32'h0);
        kick(32'hC000, 32'hD000, 16'd1, 1'b0);
        #1 chk("err_sticky", {31'b0, err}, 32'd1);
        wait_done(0, 0, lat);
        chk("err_clear_latency", lat, 32'd3);
        chk("err_cleared", {31'b0, err}, 32'd0);

        // Abort raised while the second read is stalled.
        stall_n = 2;
        kick(32'h5000, 32'h6000, 16'd8, 1'b0);
        wait_done(0, 7, lat);
        stall_n = 0;
        chk("abort_latency", lat, 32'd10);
        chk("abort_count", log_q.size(), 32'd3);
        chk_txn("abort0", 0, 1'b0, 32'h5000, 32'h0);
        chk_txn("abort1", 1, 1'b1, 32'h6000, 32'hC0DE5000);
        chk_txn("abort2", 2, 1'b0, 32'h5004, 32'h0);
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_req", {31'b0, bus.req}, 32'd0);

        // Fill request with destination wrap.
        kick(32'h7000, 32'hFFFFFFF8, 16'd3, 1'b1);
        wait_done(0, 0, lat);
        fill_mode = 1'b0;
`ifdef MEMIF_DMA_FILL_EN
        chk("fill_latency", lat, 32'd4);
        chk("fill_count", log_q.size(), 32'd3);
        chk_txn("fill0", 0, 1'b1, 32'hFFFFFFF8, 32'hA5A5A5A5);
        chk_txn("fill1", 1, 1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5);
        chk_txn("fill2", 2, 1'b1, 32'h00000000, 32'hA5A5A5A5);
`else
        chk("nofill_latency", lat, 32'd7);
        chk("nofill_count", log_q.size(), 32'd6);
        chk_txn("nofill0", 0, 1'b0, 32'h7000, 32'h0);
        chk_txn("nofill1", 1, 1'b1, 32'hFFFFFFF8, 32'hC0DE7000);
        chk_txn("nofill3", 3, 1'b1, 32'hFFFFFFFC, 32'hC0DE7004);
        chk_txn("nofill5", 5, 1'b1, 32'h00000000, 32'hC0DE7008);
`endif

        // Zero length.
        kick(32'h1000, 32'h2000, 16'd0, 1'b0);
        wait_done(0, 0, lat);
        chk("len0_latency", lat, 32'd2);
        chk("len0_count", log_q.size(), 32'd0);

        // Start held into the busy cycle with new arguments is ignored.
        kick(32'h8000, 32'h9000, 16'd1, 1'b0);
        @(negedge clk);
        src_addr = 32'hA000;
        dst_addr = 32'hB000;
        length   = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, 0, lat);
        chk("busy_start_latency", lat, 32'd3);
        repeat (4) @(negedge clk);
        chk("busy_start_idle", {31'b0, busy}, 32'd0);
        chk("busy_start_count", log_q.size(), 32'd2);
        chk_txn("busy_start0", 0, 1'b0, 32'h8000, 32'h0);
        chk_txn("busy_start1", 1, 1'b1, 32'h9000, 32'hC0DE8000);

        // Asynchronous reset in the middle of a stalled read.
        stall_n = 10;
        kick(32'hE000, 32'hF000, 16'd4, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_req_before", {31'b0, bus.req}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_req_after", {31'b0, bus.req}, 32'd0);
        chk("mid_busy_after", {31'b0, busy}, 32'd0);
        chk("mid_addr_after", bus.addr, 32'd0);
        chk("mid_clk_req_after", {31'b0, clk_req}, 32'd0);
        @(negedge clk);
        resetn  = 1'b1;
        stall_n = 0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("mid_no_done", seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
